seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display_pkg.sv | 33 +++
 rtl/seg_scan_display_hex_decode.sv | 32 +++
 rtl/seg_scan_display.sv | 135 +++++++++++++
 tb/tb_seg_scan_display.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scanner:
// scan state encoding, active-low glyph set and timing defaults.
package seg_scan_display_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    localparam int DIV_DEFAULT   = 50000;
    localparam int GUARD_DEFAULT = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_scan_display_hex_decode.sv
// Hex nibble to active-low seven-segment glyph ({g,f,e,d,c,b,a}).
module seg_hex_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment scanner with tear-free, frame-aligned
// value updates and optional leading-zero blanking.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   DRIVE | one anode low, segments show the current digit, DIV cycles
//   BLANK | all anodes off (ghosting guard), GUARD cycles, then next digit
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int GUARD = GUARD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int PW = $clog2(DIV);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    scan_state_t   state, state_nxt;
    logic [1:0]    digit, digit_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [GW-1:0] guard, guard_nxt;
    logic          boundary;

    logic [15:0]   display;
    logic [15:0]   shadow;
    logic          pending;

    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          zero_3, zero_32, zero_321;
    logic [3:0]    lz_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BLANK;
            digit      <= 2'd3;
            presc      <= '0;
            guard      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit      <= digit_nxt;
            presc      <= presc_nxt;
            guard      <= guard_nxt;
            frame_done <= boundary;
        end
    end

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        presc_nxt = presc;
        guard_nxt = guard;
        boundary  = 1'b0;
        case (state)
            ST_DRIVE: begin
                if (presc == PRESC_LAST) begin
                    state_nxt = ST_BLANK;
                    guard_nxt = '0;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            ST_BLANK: begin
                if (guard == GUARD_LAST) begin
                    state_nxt = ST_DRIVE;
                    presc_nxt = '0;
                    digit_nxt = digit + 2'd1;
                    boundary  = (digit == 2'd3);
                end else begin
                    guard_nxt = guard + 1'b1;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // Display only changes on the frame boundary so no frame ever tears;
    // a load landing exactly on the boundary bypasses the shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                display <= value;
                shadow  <= value;
                pending <= 1'b0;
            end else if (pending) begin
                display <= shadow;
                pending <= 1'b0;
            end
        end else if (load) begin
            shadow  <= value;
            pending <= 1'b1;
        end
    end

    assign nibble   = display[{digit, 2'b00} +: 4];
    assign zero_3   = (display[15:12] == 4'h0);
    assign zero_32  = zero_3 && (display[11:8] == 4'h0);
    assign zero_321 = zero_32 && (display[7:4] == 4'h0);
    assign lz_mask  = {zero_3, zero_32, zero_321, 1'b0};

    seg_hex_decode u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        an_n  = 4'hF;
        seg_n = SEG_BLANK;
        dp_n  = 1'b1;
        if (state == ST_DRIVE) begin
            an_n  = ~(4'b0001 << digit);
            seg_n = (blank_lz && lz_mask[digit]) ? SEG_BLANK : glyph;
            dp_n  = ~dp_mask[digit];
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIV=4, GUARD=2 (24-cycle frame).
module tb_seg_scan_display;

    localparam int DIV   = 4;
    localparam int GUARD = 2;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp,
                             input logic e_fd);
        checks++;
        assert (an_n === e_an) else begin
            errors++;
            $error("FAIL %s an_n observed=%h expected=%h", tag, an_n, e_an);
        end
        checks++;
        assert (seg_n === e_seg) else begin
            errors++;
            $error("FAIL %s seg_n observed=%h expected=%h", tag, seg_n, e_seg);
        end
        checks++;
        assert (dp_n === e_dp) else begin
            errors++;
            $error("FAIL %s dp_n observed=%b expected=%b", tag, dp_n, e_dp);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL %s frame_done observed=%b expected=%b", tag, frame_done, e_fd);
        end
    endtask

    // Walks one frame from the first DRIVE cycle of digit 0, checking every
    // cycle; optional one-cycle load pulses are launched after cycle la0/la1.
    task automatic check_frame(input string tag,
                               input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3,
                               input logic [3:0] dpm, input int ncyc,
                               input int la0, input logic [15:0] lv0,
                               input int la1, input logic [15:0] lv1);
        logic [6:0] gl [4];
        int i;
        gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
        i = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV + GUARD; c++) begin
                if (i < ncyc) begin
                    @(negedge clk);
                    load = 1'b0;
                    if (c < DIV)
                        check_now($sformatf("%s d%0d c%0d", tag, d, c),
                                  ~(4'b0001 << d), gl[d], ~dpm[d],
                                  (d == 0 && c == 0));
                    else
                        check_now($sformatf("%s d%0d guard%0d", tag, d, c - DIV),
                                  4'hF, 7'h7F, 1'b1, 1'b0);
                    if (i == la0) begin value = lv0; load = 1'b1; end
                    if (i == la1) begin value = lv1; load = 1'b1; end
                end
                i++;
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        value    = 16'h0000;
        load     = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;

        @(negedge clk);
        @(negedge clk);
        check_now("in_reset", 4'hF, 7'h7F, 1'b1, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_now("post_reset_guard", 4'hF, 7'h7F, 1'b1, 1'b0);

        // Idle scan of zeros, then a mid-frame load that must not tear
        check_frame("f1_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 24, -1, 16'h0, -1, 16'h0);
        check_frame("f2_old", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 24, 5, 16'hA1F8, -1, 16'h0);

        // A1F8 now visible; two loads in one frame, only the last survives
        check_frame("f3_a1f8", 7'h00, 7'h0E, 7'h79, 7'h08, 4'b0000, 24, 3, 16'h1234, 10, 16'h5678);

        // 5678 with decimal points on digits 0 and 2; load on the boundary
        dp_mask = 4'b0101;
        check_frame("f4_5678", 7'h00, 7'h78, 7'h02, 7'h12, 4'b0101, 24, 23, 16'h0042, -1, 16'h0);

        // Boundary load committed directly, leading zeros blanked, dp unaffected
        blank_lz = 1'b1;
        check_frame("f5_0042", 7'h24, 7'h19, 7'h7F, 7'h7F, 4'b0101, 24, -1, 16'h0, -1, 16'h0);
        check_frame("f6_0042", 7'h24, 7'h19, 7'h7F, 7'h7F, 4'b0101, 24, -1, 16'h0, -1, 16'h0);

        // Pending load then reset during digit 2
        blank_lz = 1'b0;
        dp_mask  = 4'b0100;
        check_frame("f7_pre_rst", 7'h24, 7'h19, 7'h40, 7'h40, 4'b0100, 14, 8, 16'h1111, -1, 16'h0);
        #2 reset = 1'b0;
        #1 check_now("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        check_now("held_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        dp_mask = 4'b0000;
        reset   = 1'b1;
        @(negedge clk);
        check_now("rerelease_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        check_frame("f8_cleared", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 24, -1, 16'h0, -1, 16'h0);
        check_frame("f9_cleared", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 24, -1, 16'h0, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
